// File: rtl/bcd_pkg.sv
// Shared constants and types for the binary-to-BCD conversion scheduler.
// Engine register layout: [47:20] seven BCD digits, [19:0] binary operand.
package bcd_pkg;

    localparam int BIN_W   = 20;
    localparam int N_DIG   = 6;
    localparam int DIG_W   = 4;
    localparam int STEPS   = BIN_W;
    localparam int ENG_DIG = N_DIG + 1;
    localparam int SR_W    = ENG_DIG * DIG_W + BIN_W;
    localparam int CNT_W   = $clog2(STEPS + 1);

    localparam logic [BIN_W-1:0] LIMIT = 20'd999999;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Digit k (1 = least significant) of the engine register, zero-extended.
    function automatic logic [7:0] dig8(input logic [SR_W-1:0] s, input int k);
        return {4'b0000, s[BIN_W + (k - 1) * DIG_W +: DIG_W]};
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
// Purely combinational.
module bcd_dabble_step
    import bcd_pkg::*;
(
    input  logic [SR_W-1:0] din,
    output logic [SR_W-1:0] dout
);

    logic [SR_W-1:0] adj;

    always_comb begin
        adj = din;
        for (int i = 0; i < ENG_DIG; i++) begin
            if (din[BIN_W + i * DIG_W +: DIG_W] >= 4'd5) begin
                adj[BIN_W + i * DIG_W +: DIG_W] =
                    din[BIN_W + i * DIG_W +: DIG_W] + 4'd3;
            end
        end
        dout = adj << 1;
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Two-port round-robin scheduler around a shared iterative double-dabble engine.
// One add-3/shift step per clock; results hold until the next completion.
module bcd_conv_sched
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [BIN_W-1:0] bin0,
    input  logic [BIN_W-1:0] bin1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [7:0]       d1,
    output logic [7:0]       d2,
    output logic [7:0]       d3,
    output logic [7:0]       d4,
    output logic [7:0]       d5,
    output logic [7:0]       d6,
    output logic             ovf,
    output logic             busy,
    output logic             owner
);

    state_t            state;
    state_t            state_n;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_step;
    logic [CNT_W-1:0]  cnt;
    logic              ptr;
    logic              grant;
    logic              gsel;
    logic              fin;

    bcd_dabble_step u_step (
        .din  (sr),
        .dout (sr_step)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // ptr holds the last owner; on a tie the other requester wins.
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        gsel    = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant   = 1'b1;
                    gsel    = (req0 && req1) ? ~ptr : req1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(STEPS - 1)) begin
                    fin     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr    <= '0;
            cnt   <= '0;
            ptr   <= 1'b1;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            d1    <= '0;
            d2    <= '0;
            d3    <= '0;
            d4    <= '0;
            d5    <= '0;
            d6    <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            owner <= 1'b0;
        end else begin
            ack0  <= grant & ~gsel;
            ack1  <= grant & gsel;
            done0 <= fin & ~owner;
            done1 <= fin & owner;
            if (grant) begin
                sr    <= {{(SR_W - BIN_W){1'b0}}, gsel ? bin1 : bin0};
                cnt   <= '0;
                owner <= gsel;
                ptr   <= gsel;
                busy  <= 1'b1;
            end else if (state == SHIFT) begin
                sr  <= sr_step;
                cnt <= cnt + 1'b1;
            end
            // All digits and ovf load together from the final step.
            if (fin) begin
                busy <= 1'b0;
                d1   <= dig8(sr_step, 6);
                d2   <= dig8(sr_step, 5);
                d3   <= dig8(sr_step, 4);
                d4   <= dig8(sr_step, 3);
                d5   <= dig8(sr_step, 2);
                d6   <= dig8(sr_step, 1);
                ovf  <= (dig8(sr_step, 7) != 8'd0);
            end
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench: transaction-level model compared every cycle,
// plus directed conversions with hand-computed digit expectations.
module tb_bcd_conv_sched;
    import bcd_pkg::*;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             req0  = 1'b0;
    logic             req1  = 1'b0;
    logic [BIN_W-1:0] bin0  = '0;
    logic [BIN_W-1:0] bin1  = '0;
    logic             ack0, ack1, done0, done1, ovf, busy, owner;
    logic [7:0]       d1, d2, d3, d4, d5, d6;

    bcd_conv_sched dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .bin0  (bin0),
        .bin1  (bin1),
        .ack0  (ack0),
        .ack1  (ack1),
        .done0 (done0),
        .done1 (done1),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .d4    (d4),
        .d5    (d5),
        .d6    (d6),
        .ovf   (ovf),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    bit          armed = 1'b0;
    bit          m_busy, m_own, m_ptr;
    int          m_cnt, m_val;
    bit          e_ack0, e_ack1, e_done0, e_done1, e_ovf;
    logic [47:0] e_d;

    function automatic logic [47:0] to_bcd(input int v);
        logic [47:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int i = 0; i < 6; i++) begin
            r[i * 8 +: 8] = 8'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            armed   = 1'b1;
            m_busy  = 1'b0;
            m_own   = 1'b0;
            m_ptr   = 1'b1;
            m_cnt   = 0;
            m_val   = 0;
            e_ack0  = 1'b0;
            e_ack1  = 1'b0;
            e_done0 = 1'b0;
            e_done1 = 1'b0;
            e_ovf   = 1'b0;
            e_d     = '0;
        end else begin
            e_ack0  = 1'b0;
            e_ack1  = 1'b0;
            e_done0 = 1'b0;
            e_done1 = 1'b0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == STEPS) begin
                    m_busy = 1'b0;
                    if (m_own) e_done1 = 1'b1;
                    else       e_done0 = 1'b1;
                    e_d   = to_bcd(m_val);
                    e_ovf = (m_val > int'(LIMIT));
                end
            end else if (req0 || req1) begin
                bit g;
                g      = (req0 && req1) ? !m_ptr : req1;
                m_busy = 1'b1;
                m_cnt  = 0;
                m_own  = g;
                m_ptr  = g;
                m_val  = g ? int'(bin1) : int'(bin0);
                if (g) e_ack1 = 1'b1;
                else   e_ack0 = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            logic [54:0] act, exp;
            act = {ack0, ack1, done0, done1, busy, owner, ovf,
                   d1, d2, d3, d4, d5, d6};
            exp = {e_ack0, e_ack1, e_done0, e_done1, m_busy, m_own, e_ovf, e_d};
            nvec++;
            if (act !== exp) begin
                nerr++;
                $display("FAIL cycle%0d: got %h want %h", cyc, act, exp);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic bit sig(input int which);
        case (which)
            0:       return ack0;
            1:       return ack1;
            2:       return done0;
            3:       return done1;
            default: return ack0 | ack1;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int lim, input string nm,
                            output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (sig(which)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            nvec++;
            nerr++;
            $display("FAIL %s: timeout got none want pulse", nm);
        end
    endtask

    function automatic logic [47:0] dig_bus();
        return {d1, d2, d3, d4, d5, d6};
    endfunction

    task automatic convert(input bit p, input logic [BIN_W-1:0] v,
                           input string nm, input logic [47:0] ed,
                           input bit eo);
        bit ok;
        int t0;
        if (p) begin bin1 = v; req1 = 1'b1; end
        else   begin bin0 = v; req0 = 1'b1; end
        wait_sig(p ? 1 : 0, 10, {nm, "_ack"}, ok);
        t0 = cyc;
        #1;
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
        wait_sig(p ? 3 : 2, 30, {nm, "_done"}, ok);
        if (ok) begin
            chk({nm, "_lat"}, 64'(cyc - t0), 64'd20);
            chk({nm, "_dig"}, 64'(dig_bus()), 64'(ed));
            chk({nm, "_ovf"}, 64'(ovf), 64'(eo));
        end
        tick();
    endtask

    initial begin
        bit ok;
        int last;
        repeat (3) tick();
        chk("reset_state", 64'({ack0, ack1, done0, done1, busy, owner, ovf,
                                dig_bus()}), 64'd0);
        reset = 1'b0;

        convert(1'b0, 20'd12345,   "single",  48'h00_01_02_03_04_05, 1'b0);
        convert(1'b1, 20'd1048575, "ovfmax",  48'h00_04_08_05_07_05, 1'b1);
        convert(1'b0, 20'd0,       "zero",    48'h00_00_00_00_00_00, 1'b0);
        convert(1'b1, 20'd999999,  "nines",   48'h09_09_09_09_09_09, 1'b0);
        convert(1'b0, 20'd1000000, "million", 48'h00_00_00_00_00_00, 1'b1);

        reset = 1'b1;
        repeat (2) tick();
        bin0  = 20'd111;
        bin1  = 20'd222;
        req0  = 1'b1;
        req1  = 1'b1;
        reset = 1'b0;
        last  = 0;
        for (int k = 0; k < 4; k++) begin
            wait_sig(4, 40, "cont_ack", ok);
            if (ok) begin
                chk("cont_who", 64'(ack1), 64'(k % 2));
                if (k > 0) chk("cont_gap", 64'(cyc - last), 64'd21);
                last = cyc;
            end
        end
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        wait_sig(3, 30, "cont_done", ok);
        if (ok) chk("cont_dig", 64'(dig_bus()), 64'h00_00_00_02_02_02);
        tick();

        bin0 = 20'd7;
        req0 = 1'b1;
        wait_sig(0, 10, "late_ack0", ok);
        #1;
        req0 = 1'b0;
        repeat (5) tick();
        bin1 = 20'd42;
        req1 = 1'b1;
        wait_sig(2, 30, "late_done0", ok);
        if (ok) chk("late_dig0", 64'(dig_bus()), 64'h00_00_00_00_00_07);
        @(negedge clk);
        chk("late_ack1", 64'(ack1), 64'd1);
        #1;
        req1 = 1'b0;
        wait_sig(3, 30, "late_done1", ok);
        if (ok) chk("late_dig1", 64'(dig_bus()), 64'h00_00_00_00_04_02);
        tick();

        bin0 = 20'd555555;
        req0 = 1'b1;
        wait_sig(0, 10, "rst_ack", ok);
        #1;
        req0 = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid", 64'({ack0, ack1, done0, done1, busy, owner, ovf,
                            dig_bus()}), 64'd0);
        #1;
        reset = 1'b0;
        convert(1'b0, 20'd321, "post_rst", 48'h00_00_00_03_02_01, 1'b0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
